// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - signed shift-add MUL, restoring DIV and single-cycle logic/shift ALU
// Define MULTICYCLE_ALU_DIV_EN to build in the iterative divider (opcode 0111); otherwise 0111 yields zeros.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0]   WIDTH_V  = (SW+1)'(WIDTH);
  localparam logic [SW-1:0] LAST_CNT = SW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_NEG  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'b0111;
`endif
  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_SHRA = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;
  localparam logic [3:0] OP_ROL  = 4'b1100;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             qneg_q, qneg_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
`ifdef MULTICYCLE_ALU_DIV_EN
  logic             op_mul_q, op_mul_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [WIDTH-1:0] quo_final, rem_final;
`endif

  logic             accept;
  logic [SW-1:0]    amt, rot;
  logic [WIDTH-1:0] abs_a, abs_b, single_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_acc, step_lo;
  logic [2*WIDTH-1:0] mul_final;

  assign accept = start && (state_q != CALC);
  assign amt    = B[SW-1:0];
  // Amounts past WIDTH only occur for non-power-of-two widths; fold them for rotates.
  assign rot    = ({1'b0, amt} >= WIDTH_V) ? amt - WIDTH_V[SW-1:0] : amt;
  assign abs_a  = A[WIDTH-1] ? -A : A;
  assign abs_b  = B[WIDTH-1] ? -B : B;

  always_comb begin
    single_lo = '0;
    case (opcode)
      OP_AND:  single_lo = A & B;
      OP_OR:   single_lo = A | B;
      OP_NOT:  single_lo = ~A;
      OP_NEG:  single_lo = -A;
      OP_ADD:  single_lo = A + B;
      OP_SUB:  single_lo = A - B;
      OP_SHR:  single_lo = A >> amt;
      OP_SHRA: single_lo = $signed(A) >>> amt;
      OP_SHL:  single_lo = A << amt;
      OP_ROR:  single_lo = (A >> rot) | (A << (WIDTH_V - {1'b0, rot}));
      OP_ROL:  single_lo = (A << rot) | (A >> (WIDTH_V - {1'b0, rot}));
      default: single_lo = '0;
    endcase
  end

  // Both iterations run on magnitudes; signs are applied on the final step.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    step_acc = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (!op_mul_q) begin
      if (!div_trial[WIDTH]) begin
        step_acc = div_trial[WIDTH-1:0];
        step_lo  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_shift[WIDTH-1:0];
        step_lo  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
    quo_final = qneg_q ? -step_lo : step_lo;
    rem_final = rneg_q ? -step_acc : step_acc;
`endif
    mul_final = qneg_q ? -{step_acc, step_lo} : {step_acc, step_lo};
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    qneg_d   = qneg_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
`ifdef MULTICYCLE_ALU_DIV_EN
    op_mul_d = op_mul_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
`endif
    case (state_q)
      CALC: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q + SW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          {res_hi_d, res_lo_d} = mul_final;
`ifdef MULTICYCLE_ALU_DIV_EN
          if (!op_mul_q) begin
            res_lo_d = quo_final;
            res_hi_d = rem_final;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (accept) begin
      qneg_d = A[WIDTH-1] ^ B[WIDTH-1];
      cnt_d  = '0;
      acc_d  = '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      dbz_d  = 1'b0;
`endif
      if (opcode == OP_MUL) begin
        state_d = CALC;
        lo_d    = abs_b;
        opnd_d  = abs_a;
`ifdef MULTICYCLE_ALU_DIV_EN
        op_mul_d = 1'b1;
      end else if (opcode == OP_DIV) begin
        if (B == '0) begin
          state_d  = DONE;
          res_lo_d = '1;
          res_hi_d = A;
          dbz_d    = 1'b1;
        end else begin
          state_d  = CALC;
          op_mul_d = 1'b0;
          lo_d     = abs_a;
          opnd_d   = abs_b;
          rneg_d   = A[WIDTH-1];
        end
`endif
      end else begin
        state_d  = DONE;
        res_lo_d = single_lo;
        res_hi_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      qneg_q   <= 1'b0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      op_mul_q <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      qneg_q   <= qneg_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
`ifdef MULTICYCLE_ALU_DIV_EN
      op_mul_q <= op_mul_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
`endif
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
`ifdef MULTICYCLE_ALU_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu at WIDTH=32
// Expectations for opcode 0111 follow MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;
  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_DIV = 4'h7;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [3:0] ABORT_OP = OP_DIV;
`else
  localparam logic [3:0] ABORT_OP = OP_MUL;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   opcode = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  multicycle_alu #(.WIDTH(W)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .opcode(opcode),
    .A(A), .B(B), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi, input logic dbz, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.dbz = dbz; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Reference: plain 64-bit signed arithmetic on the operands.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic dbz, output int lat);
    longint sa, sb, t;
    int s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[4:0]);
    lo = '0; hi = '0; dbz = 1'b0; lat = 0; t = 0;
    case (op)
      4'h0: lo = a & b;
      4'h1: lo = a | b;
      4'h2: lo = ~a;
      4'h3: begin t = -sa; lo = t[31:0]; end
      4'h4: lo = a + b;
      4'h5: lo = a - b;
      4'h6: begin t = sa * sb; lo = t[31:0]; hi = t[63:32]; lat = 32; end
      4'h7: begin
`ifdef MULTICYCLE_ALU_DIV_EN
        if (b == 32'd0) begin
          lo = '1; hi = a; dbz = 1'b1;
        end else begin
          t = sa / sb; lo = t[31:0];
          t = sa % sb; hi = t[31:0];
          lat = 32;
        end
`endif
      end
      4'h8: lo = a >> s;
      4'h9: lo = $signed(a) >>> s;
      4'hA: lo = a << s;
      4'hB: lo = (a >> s) | (a << (32 - s));
      4'hC: lo = (a << s) | (a >> (32 - s));
      default: ;
    endcase
  endfunction

  task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi, input logic edbz, input int elat);
    int   lat;
    logic busy_ok;
    @(negedge clock);
    start = 1'b1; opcode = op; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0; opcode = 4'($urandom); A = $urandom; B = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    if (busy) busy_ok = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_lo"}, 64'(result_lo), 64'(elo));
    check({tag, "_hi"}, 64'(result_hi), 64'(ehi));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, {result_hi, result_lo}, {ehi, elo});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [3:0]  op;
    logic [31:0] ra, rb, elo, ehi;
    logic        edbz;
    int          elat;

    add_vec(4'h4, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b0, 0);
    add_vec(4'h6, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 32);
    add_vec(4'hB, 32'h80000001, 32'h1,        32'hC0000000, 32'h0,        1'b0, 0);
    add_vec(4'h9, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32'h0,        1'b0, 0);
    add_vec(4'h9, 32'h80000000, 32'd0,        32'h80000000, 32'h0,        1'b0, 0);
    add_vec(4'h5, 32'd5,        32'd7,        32'hFFFFFFFE, 32'h0,        1'b0, 0);
    add_vec(4'h3, 32'd1,        32'h1234,     32'hFFFFFFFF, 32'h0,        1'b0, 0);
    add_vec(4'h2, 32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0, 32'h0,        1'b0, 0);
    add_vec(4'h0, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 32'h0,        1'b0, 0);
    add_vec(4'h1, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0,        1'b0, 0);
    add_vec(4'hA, 32'h1,        32'h24,       32'h10,       32'h0,        1'b0, 0);
    add_vec(4'h8, 32'h80000000, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 0);
    add_vec(4'hC, 32'h80000001, 32'h0,        32'h80000001, 32'h0,        1'b0, 0);
    add_vec(4'hC, 32'h80000001, 32'h4,        32'h00000018, 32'h0,        1'b0, 0);
    add_vec(4'hE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 0);
    add_vec(4'hF, 32'h12345678, 32'h9,        32'h0,        32'h0,        1'b0, 0);
    add_vec(4'h6, 32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 1'b0, 32);
    add_vec(4'h6, 32'h0,        32'h12345,    32'h0,        32'h0,        1'b0, 32);
`ifdef MULTICYCLE_ALU_DIV_EN
    add_vec(4'h7, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32);
    add_vec(4'h7, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 0);
    add_vec(4'h4, 32'd1,        32'd1,        32'd2,        32'h0,        1'b0, 0);
    add_vec(4'h7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 32);
    add_vec(4'h7, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 32);
`else
    add_vec(4'h7, 32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        1'b0, 0);
    add_vec(4'h7, 32'd5,        32'd0,        32'h0,        32'h0,        1'b0, 0);
`endif

    // Reset: start held high while clear_n is low must be ignored.
    clear_n = 1'b0; start = 1'b1; opcode = OP_MUL; A = 32'd3; B = 32'd5;
    @(posedge clock); #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_lo", 64'(result_lo), 64'd0);
    check("reset_hi", 64'(result_hi), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clock);
    start = 1'b0; clear_n = 1'b1;
    @(posedge clock); #1;
    check("post_reset_idle", 64'({busy, done}), 64'd0);

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].lo, vecs[i].hi, vecs[i].dbz, vecs[i].lat);

    // Back-to-back: SUB accepted in ADD's DONE cycle, MUL in SUB's DONE cycle.
    @(negedge clock);
    start = 1'b1; opcode = OP_ADD; A = 32'd10; B = 32'd20;
    @(posedge clock); #1;
    check("b2b_add_done", 64'(done), 64'd1);
    check("b2b_add_lo", 64'(result_lo), 64'd30);
    opcode = OP_SUB;
    @(posedge clock); #1;
    check("b2b_sub_done", 64'(done), 64'd1);
    check("b2b_sub_lo", 64'(result_lo), 64'hFFFFFFF6);
    opcode = OP_MUL; A = 32'd6; B = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_mul_busy", 64'({busy, done}), 64'b10);
    check("b2b_mul_held", 64'(result_lo), 64'hFFFFFFF6);
    lat = 0;
    while (!done && lat < 100) begin @(posedge clock); #1; lat++; end
    check("b2b_mul_latency", 64'(lat), 64'd32);
    check("b2b_mul_result", {result_hi, result_lo}, 64'd42);
    @(posedge clock); #1;

    // A start pulsed in the middle of a MUL must be ignored.
    @(negedge clock);
    start = 1'b1; opcode = OP_MUL; A = 32'hFFFFFFFD; B = 32'd7;
    @(posedge clock); #1;
    start = 1'b0; A = 32'd100; B = 32'd100;
    repeat (10) @(posedge clock);
    #1;
    start = 1'b1; opcode = OP_ADD; A = 32'd1; B = 32'd1;
    @(posedge clock); #1;
    start = 1'b0;
    check("midmul_busy", 64'({busy, done}), 64'b10);
    lat = 11;
    while (!done && lat < 100) begin @(posedge clock); #1; lat++; end
    check("midmul_latency", 64'(lat), 64'd32);
    check("midmul_result", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFEB);
    @(posedge clock); #1;

    // clear_n mid-operation clears every output at once, then the next op runs cleanly.
    @(negedge clock);
    start = 1'b1; opcode = ABORT_OP; A = 32'hFFFFFFF9; B = 32'd2;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #3;
    check("abort_inflight", 64'(busy), 64'd1);
    clear_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_lo", 64'(result_lo), 64'd0);
    check("abort_hi", 64'(result_hi), 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    @(posedge clock); #1;
    check("abort_idle", 64'({busy, done}), 64'd0);
    @(negedge clock);
    clear_n = 1'b1;
    model(ABORT_OP, 32'hFFFFFFF9, 32'd2, elo, ehi, edbz, elat);
    apply("after_abort", ABORT_OP, 32'hFFFFFFF9, 32'd2, elo, ehi, edbz, elat);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(0, 40));
        2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: rb = 32'($urandom);
      endcase
      model(op, ra, rb, elo, ehi, edbz, elat);
      apply($sformatf("rnd%0d_op%0h", i, op), op, ra, rb, elo, ehi, edbz, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, any even value from 8 to 64.
REQ-002 SHALL have port clock, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port clear_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: request to begin an operation.
REQ-005 SHALL have port opcode, input, 4: operation select.
REQ-006 SHALL have ports A and B, input, WIDTH each: operands.
REQ-007 SHALL have port busy, output, 1: high while a multi-cycle operation is iterating.
REQ-008 SHALL have port done, output, 1: one-cycle pulse marking a new valid result.
REQ-009 SHALL have ports result_lo and result_hi, output, WIDTH each: result low and high halves.
REQ-010 SHALL have port div_by_zero, output, 1: set with done when DIV has B == 0.

Function
REQ-011 SHALL decode opcode as follows: 0000 AND, 0001 OR, 0010 NOT A, 0011 NEG A, 0100 ADD, 0101 SUB (A-B), 0110 MUL, 0111 DIV, 1000 SHR, 1001 SHRA, 1010 SHL, 1011 ROR, 1100 ROL.
REQ-012 SHALL implement an FSM with states IDLE, CALC and DONE; start is accepted only in IDLE or DONE, and is ignored while in CALC.
REQ-013 SHALL latch opcode, A and B on the accepting edge; later input changes SHALL NOT affect the operation in flight.
REQ-014 SHALL, for single-cycle ops (everything except MUL and DIV), go from IDLE/DONE to DONE on the accepting edge N, with the result registered and done=1 in the cycle after edge N.
REQ-015 SHALL, for single-cycle ops, put the result in result_lo and drive result_hi to 0; ADD/SUB/NEG wrap modulo 2^WIDTH.
REQ-016 SHALL use B[log2(WIDTH)-1:0] as the shift/rotate amount; SHRA sign-extends; an amount of 0 returns A unchanged.
REQ-017 SHALL implement MUL as signed two's-complement iterative shift-add, one bit per cycle, giving the full 2*WIDTH product on {result_hi,result_lo}.
REQ-018 SHALL implement DIV as signed iterative restoring division: quotient in result_lo, remainder in result_hi, remainder sign equal to the dividend sign, quotient truncated toward zero.
REQ-019 SHALL, for MUL/DIV accepted at edge N, hold busy=1 from after edge N until edge N+WIDTH, then enter DONE with done=1 in the following cycle.
REQ-020 SHALL, for DIV with B == 0, skip CALC and enter DONE at edge N with result_lo=all ones, result_hi=A and div_by_zero=1.
REQ-021 SHALL clear div_by_zero on the next accepted start.
REQ-022 SHALL treat the most-negative-value / -1 DIV case as wrapping: quotient = most-negative value, remainder 0.
REQ-023 SHALL treat opcodes 1101-1111 as single-cycle with both result halves 0.
REQ-024 SHALL hold result_lo/result_hi stable from done until the next done; DONE SHALL return to IDLE after one cycle unless a new start is accepted.
REQ-025 SHALL allow back-to-back operations: a start during the DONE cycle is accepted, with no idle cycle inserted.

Reset
REQ-026 SHALL, on clear_n low, immediately force state=IDLE and busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0, aborting any operation in flight.
REQ-027 SHALL ignore start in the first edge after clear_n deasserts only if clear_n is still low at that edge.

Configuration
REQ-028 SHALL, with macro MULTICYCLE_ALU_DIV_EN defined, include the iterative divider as specified above.
REQ-029 SHALL, without MULTICYCLE_ALU_DIV_EN, treat opcode 0111 as an unsupported opcode per REQ-023, omit all divider logic, and hold div_by_zero at 0.

Verification
REQ-030 SHALL cover, with WIDTH=32: ADD A=0xFFFFFFFF, B=1 -> done one cycle after start, result_lo=0, result_hi=0.
REQ-031 SHALL cover: MUL A=-3, B=7 -> busy for 32 cycles, then done with {hi,lo}=0xFFFFFFFF_FFFFFFEB.
REQ-032 SHALL cover: DIV A=-7, B=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV A=5, B=0 -> done after 1 cycle, div_by_zero=1, lo=0xFFFFFFFF, hi=5.
REQ-033 SHALL cover: ROR A=0x80000001, B=1 -> 0xC0000000; SHRA A=0x80000000, B=31 -> 0xFFFFFFFF.
REQ-034 SHALL cover: start pulsed mid-MUL -> ignored, and the MUL result is unchanged; start in the DONE cycle -> accepted back-to-back.
REQ-035 SHALL cover: clear_n asserted at cycle 10 of a DIV -> all outputs 0 at once, state IDLE, and the next op runs correctly.
